// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the round-robin select arbiter.
package arb_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } arb_state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request after `last`, ascending with wrap.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] last,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            // 2-bit addition wraps naturally, giving (last+1+i) mod 4
            cand = last + SEL_W'(i + 1);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter owning the mux/demux select, with hold-limit timeout and a one-cycle TURN gap between owners.
module rr_sel_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  req,
    input  logic             release_in,
    output logic [SEL_W-1:0] sel,
    output logic [N_CH-1:0]  gnt,
    output logic             busy,
    output logic             timeout
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [N_CH-1:0]  gnt_q, gnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             end_rel;
    logic             end_limit;

    rr_pick4 u_pick (
        .req   (req),
        .last  (last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign end_rel   = release_in | ~req[sel_q];
    assign end_limit = (hold_q == HOLD_W'(MAX_HOLD));

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE, TURN: begin
                gnt_d  = '0;
                hold_d = '0;
                if (pick_found) begin
                    state_d = GRANT;
                    gnt_d   = {{(N_CH-1){1'b0}}, 1'b1} << pick_idx;
                    sel_d   = pick_idx;
                    last_d  = pick_idx;
                    hold_d  = HOLD_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (end_rel || end_limit) begin
                    state_d   = TURN;
                    gnt_d     = '0;
                    hold_d    = '0;
                    // release/withdrawal takes precedence: no timeout pulse
                    timeout_d = end_limit & ~end_rel;
                end else if (!end_limit) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                hold_d  = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            last_q    <= SEL_W'(N_CH - 1);
            gnt_q     <= '0;
            hold_q    <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            hold_q    <= hold_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign sel     = sel_q;
    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule
